// File: rtl/sift_compactor.sv
// -----------------------------------------------------------------------------
// sift_compactor
//
// Streaming BB84-style sifter. Each input beat carries LANES qubits together
// with the sender and receiver basis choices. A lane is kept when both bases
// agree and the qubit polarisation belongs to the sender's basis. The kept bits
// are packed densely, oldest first, into KEY_W-bit key words. Words stream out
// until KEY_BITS key bits have been delivered, and then the block reports done.
//
// Optional feature (macro SIFT_STATS_EN): this adds the saturating counters
// stat_seen and stat_kept.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              one-cycle pulse; opens a session from IDLE or DONE
//   in_valid/in_ready  input beat handshake
//   qubit              lane i at [2i+:2]: 00=0deg 01=90deg 10=45deg 11=135deg
//   sender_bases       lane i sender basis (0 rectilinear, 1 diagonal)
//   receiver_bases     lane i receiver basis
//   out_valid/out_ready key word handshake
//   out_key            key word; bit 0 is the oldest key bit
//   busy               session in RUN or FLUSH
//   done               KEY_BITS delivered; held until start or rst
//   stat_seen          (SIFT_STATS_EN) qubits accepted
//   stat_kept          (SIFT_STATS_EN) sifted bits, including discarded residue
// -----------------------------------------------------------------------------
module sift_compactor #(
    parameter int LANES    = 8,
    parameter int KEY_W    = 32,
    parameter int KEY_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*LANES-1:0]   qubit,
    input  logic [LANES-1:0]     sender_bases,
    input  logic [LANES-1:0]     receiver_bases,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [KEY_W-1:0]     out_key,
    output logic                 busy,
    output logic                 done
`ifdef SIFT_STATS_EN
    ,
    output logic [31:0]          stat_seen,
    output logic [31:0]          stat_kept
`endif
);

    // A beat is only accepted while fewer than KEY_W bits are buffered, so the
    // buffer never needs more than KEY_W-1 old bits plus LANES new ones.
    localparam int ACC_W  = KEY_W + LANES - 1;
    localparam int CNT_W  = $clog2(KEY_W + LANES);
    localparam int NWORDS = KEY_BITS / KEY_W;
    localparam int WC_W   = $clog2(NWORDS + 1);
    localparam int PC_W   = $clog2(LANES + 1);

    localparam logic [CNT_W-1:0] KEY_W_C     = CNT_W'(KEY_W);
    localparam logic [WC_W-1:0]  LAST_WORD_C = WC_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [KEY_W-1:0] out_key_q, out_key_d;

    logic [LANES-1:0] keep;
    logic [LANES-1:0] packed_bits;
    logic [PC_W-1:0]  pc;

    logic in_fire;
    logic out_load;
    logic out_fire;
    logic start_ok;
    logic last_load;

    // -------------------------------------------------------------------------
    // Lane sifting and compaction. The kept bits are gathered in ascending lane
    // order into the low bits of packed_bits. pc counts how many lanes kept.
    // -------------------------------------------------------------------------
    always_comb begin
        keep        = '0;
        packed_bits = '0;
        pc          = '0;
        for (int i = 0; i < LANES; i++) begin
            // qubit[2i+1] is the polarisation's basis and qubit[2i] is its bit.
            keep[i] = (sender_bases[i] == receiver_bases[i]) &&
                      (qubit[2*i+1] == sender_bases[i]);
            if (keep[i]) begin
                packed_bits = packed_bits | (LANES'(qubit[2*i]) << pc);
                pc          = pc + PC_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    // Words load only in RUN. After the final word, the residue is left to rot.
    assign out_load  = (state_q == S_RUN) && (acc_cnt_q >= KEY_W_C) &&
                       (!out_valid_q || out_ready);
    assign last_load = out_load && (word_cnt_q == LAST_WORD_C);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_RUN;
            // Leave RUN on the edge that loads the final word, so that in_ready
            // is already low while that word waits in the output register.
            S_RUN:   if (last_load) state_d = S_FLUSH;
            S_FLUSH: if (out_fire)  state_d = S_DONE;
            S_DONE:  if (start)     state_d = S_RUN;
            default:                state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == S_RUN) && (acc_cnt_q < KEY_W_C);
        busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
        done     = (state_q == S_DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath next state. The output load shifts the accumulator first, and
    // then an accepted beat lands directly above whatever remainder is left.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;

        if (out_fire) out_valid_d = 1'b0;

        if (out_load) begin
            out_key_d   = acc_q[KEY_W-1:0];
            out_valid_d = 1'b1;
            acc_d       = acc_q >> KEY_W;
            acc_cnt_d   = acc_cnt_q - KEY_W_C;
            word_cnt_d  = word_cnt_q + WC_W'(1);
        end

        if (in_fire) begin
            acc_d     = acc_d | (ACC_W'(packed_bits) << acc_cnt_d);
            acc_cnt_d = acc_cnt_d + CNT_W'(pc);
        end

        // start is only honoured outside a session, where no load or beat can
        // be in flight, so clearing here cannot drop live data.
        if (start_ok) begin
            acc_d      = '0;
            acc_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            word_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;

`ifdef SIFT_STATS_EN
    // -------------------------------------------------------------------------
    // Session statistics. Both counters saturate rather than wrap.
    // -------------------------------------------------------------------------
    logic [31:0] stat_seen_q, stat_seen_d;
    logic [31:0] stat_kept_q, stat_kept_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        stat_seen_d = stat_seen_q;
        stat_kept_d = stat_kept_q;
        if (start_ok) begin
            stat_seen_d = '0;
            stat_kept_d = '0;
        end else if (in_fire) begin
            stat_seen_d = sat_add(stat_seen_q, 32'(LANES));
            stat_kept_d = sat_add(stat_kept_q, 32'(pc));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_seen_q <= '0;
            stat_kept_q <= '0;
        end else begin
            stat_seen_q <= stat_seen_d;
            stat_kept_q <= stat_kept_d;
        end
    end

    assign stat_seen = stat_seen_q;
    assign stat_kept = stat_kept_q;
`endif

endmodule

// File: doc/sift_compactor.md
Name: sift_compactor

Overview:
- Streaming successor to the 640-qubit bulk sifter.
- Accepts LANES qubits per beat over a valid/ready handshake. Per lane, it compares sender and receiver bases and checks that the qubit encoding is consistent with the sender basis.
- Sifted key bits are packed densely into KEY_W-bit words and streamed out until KEY_BITS key bits have been produced, then the block reports done.
- Sits between the qubit/basis source and privacy amplification / key storage.

Parameters:
- LANES, 8, qubits per input beat; must satisfy 1 <= LANES <= KEY_W.
- KEY_W, 32, output key word width.
- KEY_BITS, 128, target key length; must be a multiple of KEY_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a key session from IDLE or DONE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- qubit  in  2*LANES  lane i at [2i+:2]: 00=0°, 01=90°, 10=45°, 11=135°.
- sender_bases  in  LANES  lane i basis: 0 rectilinear, 1 diagonal.
- receiver_bases  in  LANES  lane i receiver basis.
- out_valid  out  1  key word valid.
- out_ready  in  1  downstream accepts the key word.
- out_key  out  KEY_W  key word; bit 0 is the oldest key bit.
- busy  out  1  state is RUN or FLUSH.
- done  out  1  KEY_BITS key bits delivered; held until start or rst.

Behaviour:
- Reset (async, immediate) values: in_ready=0, out_valid=0, out_key=0, busy=0, done=0, accumulator and all counters 0, state=IDLE.
- Lane keep rule: keep[i] = (sender_bases[i]==receiver_bases[i]) && (qubit[2i+1]==sender_bases[i]). Kept bit = qubit[2i]. Lanes that fail are discarded silently.
- Compaction: kept bits of a beat are appended in ascending lane order at accumulator position acc_cnt. acc_cnt increases by popcount(keep).
  - Accumulator width is KEY_W+LANES-1.
  - acc_cnt range is 0..KEY_W+LANES-1.
- Input handshake:
  - in_ready = (state==RUN) && (acc_cnt < KEY_W).
  - A beat transfers when in_valid && in_ready. A beat with zero kept lanes is still consumed.
- Output transfer: when acc_cnt >= KEY_W and (!out_valid || out_ready):
  - out_key <= acc[KEY_W-1:0].
  - out_valid <= 1.
  - The accumulator shifts down by KEY_W and acc_cnt -= KEY_W.
  - Output load and input append may occur in the same cycle; the new beat lands after the shifted remainder.
- out_valid and out_key remain stable until out_ready. out_valid drops the cycle after acceptance unless a new word loads.
- Latency: a beat completing a word produces out_valid on the next rising edge when the output register is free.
- word_cnt counts loaded words.
- FSM:
  - IDLE: all idle. start -> RUN; start also clears acc, acc_cnt, word_cnt and done.
  - RUN: accepts beats. When word_cnt reaches KEY_BITS/KEY_W -> FLUSH. in_ready is 0 from the same cycle the last word loads.
  - FLUSH: waits for the last word handshake. Residual accumulator bits beyond KEY_BITS are discarded. On out_valid&&out_ready -> DONE.
  - DONE: done=1. start -> RUN with everything cleared.
- start while RUN or FLUSH is ignored.
- rst mid-session aborts immediately; the pending output word is lost.
- in_valid while not in RUN has no effect.

Optional Feature:
- Macro SIFT_STATS_EN.
- When defined, add outputs:
  - stat_seen (32 bits): qubits received, incremented by LANES per accepted beat.
  - stat_kept (32 bits): sifted bits, incremented by popcount(keep) per accepted beat, including bits later discarded.
- Both counters clear on rst and on an accepted start, and saturate at 2^32-1.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use LANES=4, KEY_W=8, KEY_BITS=16.
- Reset values: assert rst asynchronously between clock edges -> all outputs 0 immediately; in_ready stays 0 until start.
- Full-keep stream:
  - Stimulus: start, then beats with bases all 0 and qubit=8'b01_00_01_00.
  - Response: two beats yield out_key=8'b01010101... lane 0 = bit 0, so out_key=8'h AA.
  - After the 4th beat: second word, FLUSH, done=1 after handshake.
- Partial keep, cross-word split:
  - Stimulus: beats keeping 3 lanes each (bits 1,0,1).
  - Response: the 3rd beat straddles the word; word 0 = 8'b01_101_101 (= 8'h6D); 1 bit carries into word 1.
- Mismatch / inconsistent encoding:
  - Stimulus: receiver_bases=~sender_bases, or sender base 0 with qubit 10.
  - Response: beat consumed, no out_valid, acc_cnt unchanged, stat_kept unchanged.
- Backpressure:
  - Stimulus: out_ready=0 with acc_cnt>=8 and out_valid=1.
  - Response: in_ready=0, out_key stable for 10 cycles; raise out_ready -> next word loads the following edge, with no lost or duplicated bits.
- Start while RUN, and rst mid-FLUSH:
  - start while RUN -> ignored, word sequence unchanged.
  - rst during FLUSH -> IDLE, done=0, out_valid=0.
  - Fresh start -> new session from word 0.
